// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle WIDTH-bit subtractor, D = A - B - Bin.
// One 4-bit lookahead slice is reused for every nibble, LSB nibble first.
// Subtraction is done as A + ~B + ~borrow, with the borrow held in a flop
// between nibbles. WIDTH must be a multiple of 4 and at least 4.

// fastcarry_4: 4-bit carry-lookahead adder slice.
module fastcarry_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ {c[3], c[2], c[1], cin};
        cout = c[4];
    end

endmodule

// State table
//   state   | meaning
//   IDLE    | waiting for start; result registers hold last result
//   RUN     | one nibble per edge, NIB edges total
//   DONE    | one-cycle done pulse; start accepted back-to-back
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       nib_s;
    logic             nib_c;
    logic [WIDTH+3:0] d_cat;
    logic [WIDTH-1:0] d_shift;
    logic             last_nib;

    // Operand shadows shift right each RUN edge, so the current nibble is
    // always in bits [3:0]; on the last nibble bit 3 is the operand sign.
    fastcarry_4 u_fc (
        .a    (a_q[3:0]),
        .b    (~b_q[3:0]),
        .cin  (~borrow_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Result enters at the top and shifts down; after NIB edges nibble 0
    // sits in D[3:0].
    always_comb begin
        d_cat    = {nib_s, d_q};
        d_shift  = d_cat[WIDTH+3:4];
        last_nib = (cnt_q == CW'(NIB - 1));
    end

    // Next-state and datapath: accept in IDLE/DONE, one nibble per RUN edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        v_d      = v_q;
        z_d      = z_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    d_d      = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                d_d      = d_shift;
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                borrow_d = ~nib_c;
                cnt_d    = cnt_q + CW'(1);
                if (last_nib) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    bout_d  = ~nib_c;
                    v_d     = (a_q[3] != b_q[3]) && (nib_s[3] != a_q[3]);
                    z_d     = (d_shift == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d != ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // All state and outputs registered; synchronous reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
            z_q      <= z_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign D     = d_q;
    assign Bout  = bout_q;
    assign V     = v_q;
    assign Z     = z_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub (WIDTH=16).
module tb_nibble_serial_sub;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         ready, busy, done;
    logic [W-1:0] D;
    logic         Bout, V, Z;

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         v;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int aborted = 0;
    int last_done = 0;
    int prev_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting at cycle %0d", name, cyc);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t   e;
        logic [W:0] f;
        f      = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        e.d    = f[W-1:0];
        e.bout = f[W];
        e.v    = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
        e.z    = (f[W-1:0] == '0);
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1, want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("D", 32'(D), 32'(e.d));
                chk("Bout", 32'(Bout), 32'(e.bout));
                chk("V", 32'(V), 32'(e.v));
                chk("Z", 32'(Z), 32'(e.z));
                chk("done_latency", 32'(cyc), 32'(e.cyc));
                chk("ready_at_done", 32'(ready), 32'd1);
            end
        end
    end

    // Waits for ready, presents operands with start=1 and returns just
    // after the accepting edge (start left high; operands scrambled).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb, input logic ev, input logic ez);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            timeout("wait_ready");
            return;
        end
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        e.d    = ed;
        e.bout = eb;
        e.v    = ev;
        e.z    = ez;
        e.cyc  = cyc + NIB + 1;
        exp_q.push_back(e);
        acc_cnt++;
        @(posedge clk);
        #1;
        A   = W'($urandom);
        B   = W'($urandom);
        Bin = 1'($urandom);
    endtask

    task automatic issue_rand();
        logic [W-1:0] a, b;
        logic         bin;
        exp_t         e;
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
        if ($urandom_range(0, 7) == 0) b = a;
        e = model(a, b, bin);
        issue(a, b, bin, e.d, e.bout, e.v, e.z);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) timeout("drain");
    endtask

    initial begin
        int n;
        int guard;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_Bout", 32'(Bout), 32'd0);
        chk("rst_V", 32'(V), 32'd0);
        chk("rst_Z", 32'(Z), 32'd0);
        rst = 1'b0;

        // Basic run with busy-length check
        issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) n++;
            @(negedge clk);
            guard++;
        end
        chk("busy_cycles", 32'(n), 32'(NIB));

        // Directed vectors, issued back-to-back
        issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        issue(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(16'h00AB, 16'h00AB, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start held through DONE: second done exactly NIB+1 cycles later
        issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
        issue(16'h1000, 16'h2000, 1'b0, 16'hF000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("b2b_spacing", 32'(last_done - prev_done), 32'(NIB + 1));

        // Start re-pulsed mid-RUN must be ignored
        issue(16'h0F0F, 16'h0101, 1'b0, 16'h0E0E, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'hFFFF;
        B = 16'h0000;
        Bin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset on second RUN cycle discards the operation
        issue(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_D", 32'(D), 32'd0);
        chk("abort_flags", 32'({Bout, V, Z}), 32'd0);
        exp_q.delete();
        aborted++;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(16'h4321, 16'h1111, 1'b1, 16'h320F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Random runs against the behavioural model
        for (int i = 0; i < 10000; i++) begin
            issue_rand();
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        chk("done_count", 32'(done_cnt), 32'(acc_cnt - aborted));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle WIDTH-bit subtractor. Computes D = A - B - Bin one 4-bit nibble per clock, LSB nibble first.
- Each nibble goes through one internal fastcarry_4 instance: B nibble inverted, carry-in = ~borrow.
- The borrow is registered between nibbles.
- It is the subtract/inverse counterpart of the team's 4-bit carry-lookahead adder, trading latency for a single adder slice.
- Sits behind the ALU datapath. It is driven by a start/done handshake from the sequencer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble cycles (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- Bin  input  1  borrow-in, captured on accepted start
- ready  output  1  high in IDLE and DONE (start will be accepted)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- D  output  WIDTH  difference, held until next accepted start
- Bout  output  1  borrow-out (1 iff A < B + Bin, unsigned)
- V  output  1  signed overflow (A[msb]!=B[msb] and D[msb]!=A[msb])
- Z  output  1  D == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset state: state=IDLE. Outputs ready=1, busy=0, done=0, D=0, Bout=0, V=0, Z=0. Nibble counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches A, B and Bin into shadow registers.
  - Internal borrow<=Bin; counter<=0; D accumulator cleared; go to RUN.
  - start=0: stay in IDLE.
- RUN, per edge:
  - Nibble i=counter: {c,s} = fastcarry_4(A[i], ~B[i], ~borrow).
  - D[4i+3:4i]<=s; borrow<=~c; counter<=counter+1.
  - On the edge processing nibble NIB-1, go to DONE. Register Bout=final borrow, V and Z at this edge.
- RUN length: exactly NIB edges. With start accepted at edge k, done is high in the cycle after edge k+NIB (WIDTH=16: 4 cycles busy).
- DONE:
  - done=1 and ready=1 for exactly one cycle.
  - start=1 at the next edge is accepted as in IDLE and goes directly to RUN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Start while busy=1 is ignored: no relatch, no error, no effect on the running operation.
- Input changes on A, B and Bin after acceptance do not affect the result.
- Result hold:
  - D, Bout, V and Z are stable from the done cycle until the edge that accepts the next start.
  - At that edge D clears and the flags are not updated again until the next DONE.
  - The intermediate D is not guaranteed meaningful while busy.
- Wrap-around: the result is modulo 2^WIDTH. Bout=1 flags an unsigned underflow.
- Bin=1 with A==B gives D=all ones, Bout=1.
- Reset asserted mid-RUN or in DONE: the next cycle is in the reset state. The partial result is discarded and no done is produced.
- rst and start high on the same edge: rst wins.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0234, Bin=0, single start pulse -> busy for 4 cycles, then done pulse with D=0x1000, Bout=0, V=0, Z=0.
- A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bout=1, V=0, Z=0.
- A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, V=1; A=0x5555, B=0x5554, Bin=1 -> D=0x0000, Z=1, Bout=0.
- Handshake cases:
  - Start re-pulsed with A=0xFFFF mid-RUN -> ignored, result unchanged.
  - Start held high through DONE with new operands -> second run begins with no idle cycle; second done occurs 5 cycles after the first.
- rst asserted on cycle 2 of RUN -> next cycle all outputs zero, ready=1, no done. A new start then completes correctly.
- 10000 random (A, B, Bin) runs -> compare D, Bout, V and Z against a behavioural A - B - Bin model at every done. Check done count equals accepted-start count.
